// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Channel-index width; a single channel still needs one bit to carry an index.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle: N_CH input streams merged into one output stream.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_w(N_CH)
);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: first set request at or after ptr wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  int                off;
  int                sum;

  // Doubling the request vector makes the rotation a plain shift: bit i of rot is channel ptr+i.
  assign dbl = {req, req};
  assign rot = N_CH'(dbl >> ptr);

  always_comb begin
    gnt_valid = 1'b0;
    off       = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_valid = 1'b1;
        off       = i;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N_CH) sum = sum - N_CH;
    gnt_idx = gnt_valid ? SEL_W'(sum) : '0;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with registered output, round-robin or fixed-select grant.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_rr_if.slave   bus
);

  logic [SEL_W-1:0] ptr;
  logic             load;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic [N_CH-1:0]  fix_req;
  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] ch_p0;
  logic             vld_p0;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Matching sel against each legal index keeps an out-of-range sel from granting anything.
  always_comb begin
    fix_req = '0;
    for (int k = 0; k < N_CH; k++) begin
      fix_req[k] = (sel == SEL_W'(k)) && bus.in_valid[k];
    end
  end

  assign load    = !vld_p0 || bus.out_ready;
  assign grant   = (mode == MODE_FIXED) ? (|fix_req) : rr_valid;
  assign gnt_idx = (mode == MODE_FIXED) ? sel : rr_idx;

  always_comb begin
    bus.in_ready = '0;
    gnt_data     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        bus.in_ready[k] = !rst && load && grant;
        gnt_data        = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p0: output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      ch_p0   <= '0;
      vld_p0  <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      vld_p0 <= grant;
      if (grant) begin
        data_p0 <= gnt_data;
        ch_p0   <= gnt_idx;
        if (mode == MODE_RR) begin
          ptr <= (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign bus.out_data  = data_p0;
  assign bus.out_ch    = ch_p0;
  assign bus.out_valid = vld_p0;

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Selects one channel per transfer, in one of two modes:
  - fixed-select mode: an external select picks the channel, as a conventional mux does;
  - round-robin mode: a fair rotating arbiter picks the channel.
- Output is registered, giving 1-cycle latency.
- Sits wherever several producers share one consumer: bus front-ends and datapath merge points.

Parameters:
- N_CH, 4, number of input channels (≥2).
- WIDTH, 8, data bits per channel.
- SEL_W, $clog2(N_CH), select/channel-id width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = round-robin arbitration, 1 = fixed select via sel.
- sel  input  SEL_W  channel index used when mode=1.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  registered index of the source channel of out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Reset dominates all other activity, including mid-transfer. in_ready is 0 while rst=1.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant, mode=0: first channel with in_valid=1 searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1. No valid channel → no grant.
- Grant, mode=1: channel sel, granted only if in_valid[sel]=1. If sel ≥ N_CH (non-power-of-2 N_CH), no grant.
- in_ready[k] = load && grant && (granted index == k). At most one bit of in_ready is set per cycle. in_ready never depends on in_valid of the same channel, except through the arbitration result.
- Transfer on input k: the edge where in_valid[k] && in_ready[k].
  - out_data <= in_data[k]; out_ch <= k; out_valid <= 1.
  - mode=0 only: ptr <= (k+1) mod N_CH, wrapping N_CH-1 → 0.
- mode=1 transfers leave ptr unchanged.
- load=1 with no grant: out_valid <= 0; out_data and out_ch hold their old values.
- load=0 (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable. No in_ready is asserted. ptr holds.
- Simultaneous output drain and input accept (out_valid=1, out_ready=1, grant): new beat replaces old in the same edge. This gives full throughput of 1 beat/cycle, with no bubble.
- Latency: an input beat appears on out_* the cycle after its transfer edge.
- Mode change: takes effect on the next grant evaluation. A beat already held in the register is unaffected.
- Fairness: in mode=0, with all channels continuously valid and out_ready=1, the grant order is 0,1,2,…,N_CH-1,0,…

Decomposition:
- Package stream_mux_pkg:
  - clog2-derived SEL_W helper;
  - MODE_RR=1'b0 and MODE_FIXED=1'b1 constants.
- Sub-module rr_arbiter (combinational):
  - inputs: req[N_CH], ptr[SEL_W];
  - outputs: gnt_valid, gnt_idx[SEL_W];
  - implemented with a doubled request vector rotated by ptr.
- The top level holds:
  - the mode mux between arbiter and sel;
  - the load logic;
  - the output register and the ptr register.

Test Plan (N_CH=4, WIDTH=8):
- Reset: drive rst=1 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0x00, out_ch=0, in_ready=0000. First grant after release is channel 0.
- Round-robin fairness: mode=0, all in_valid=1, in_data ch k=0x10+k, out_ready=1 held → out_ch sequence 0,1,2,3,0,1. out_data sequence 0x10,0x11,0x12,0x13,0x10. out_valid continuous.
- Back-pressure: mode=0, out_ready=0 for 3 cycles after first beat 0x10 → out_data stays 0x10, out_ch stays 0, in_ready=0000 for those cycles. On out_ready=1, the next beat is from ch1 (0x11).
- Sparse/wrap: ptr=3 (after ch2 transfer), only ch1 valid → ch1 granted, next ptr=2. Then only ch3 and ch0 valid → ch3 first, then ch0.
- Fixed select: mode=1, sel=2, all valid → in_ready=0100 every cycle, out_data=0x12 repeatedly, ptr unchanged. With in_valid[2]=0 → out_valid drops to 0 the next cycle when out_ready=1.
- Reset mid-stream: rst=1 while out_valid=1, out_ready=0 → next cycle out_valid=0 and ptr=0. The pending beat is discarded.
